// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between the main pipeline (req 0) and the coprocessor (req 1).
// Round-robin grant, registered operands/result, optional lock for carry-chained multi-word ops.
module alu_arbiter #(
  parameter int LOCK_MAX     = 4,
  parameter int LOCK_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [63:0] req_src_a,
  input  logic [63:0] req_src_b,
  input  logic [7:0]  req_ctrl,
  input  logic [9:0]  req_attr,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_result,
  output logic [3:0]  rsp_flags,
  output logic [31:0] alu_src_a,
  output logic [31:0] alu_src_b,
  output logic [3:0]  alu_control,
  output logic        alu_c_flag,
  output logic        alu_is_arith,
  output logic        alu_is_adc,
  output logic        alu_sh_carry,
  input  logic [31:0] alu_result,
  input  logic [3:0]  alu_flags
);
  localparam int LCW = $clog2(LOCK_MAX + 1);
  localparam int ICW = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  typedef struct packed {
    logic lock;
    logic chain_c;
    logic c_flag;
    logic is_arith;
    logic is_adc;
  } attr_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    attr_t       attr;
  } op_t;

  state_t         state, state_nx;
  op_t [1:0]      op_in;
  op_t            op_q;
  logic [1:0]     elig;
  logic           win, accept, gnt_q, last_grant;
  logic           lock, lock_owner, prev_c;
  logic [LCW-1:0] lock_cnt;
  logic [ICW-1:0] idle_cnt;
  logic           lock_hit, force_clr, idle_tick, timeout, rsp_done;

  for (genvar i = 0; i < 2; i++) begin : g_req
    assign op_in[i] = {req_src_a[32*i +: 32], req_src_b[32*i +: 32],
                       req_ctrl[4*i +: 4], req_attr[5*i +: 5]};
    // while locked, only the owner may compete
    assign elig[i]  = req_valid[i] & (~lock | (lock_owner == 1'(i)));
  end

  always_comb begin
    win = 1'b0;
    case (elig)
      2'b10:   win = 1'b1;
      2'b11:   win = ~last_grant;
      default: win = 1'b0;
    endcase
  end

  assign accept    = (state == IDLE) & (|elig);
  assign req_ready = accept ? (win ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_valid = (state == RESP) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_done  = (state == RESP) & rsp_ready[gnt_q];

  // lock_cnt only advances when the other requester is actually being starved
  assign lock_hit  = accept & op_in[win].attr.lock & req_valid[~win];
  assign force_clr = lock_hit & (lock_cnt == LCW'(LOCK_MAX - 1));
  assign idle_tick = (state == IDLE) & lock & ~req_valid[lock_owner];
  assign timeout   = idle_tick & (idle_cnt == ICW'(LOCK_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = EXEC;
      EXEC:    state_nx = RESP;
      RESP:    if (rsp_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= '0;
      gnt_q      <= 1'b0;
      last_grant <= 1'b1;
      rsp_result <= '0;
      rsp_flags  <= '0;
      prev_c     <= 1'b0;
    end else begin
      if (accept) begin
        op_q       <= op_in[win];
        gnt_q      <= win;
        last_grant <= win;
      end
      if (state == EXEC) begin
        rsp_result <= alu_result;
        rsp_flags  <= alu_flags;
        prev_c     <= alu_flags[1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock       <= 1'b0;
      lock_owner <= 1'b0;
      lock_cnt   <= '0;
      idle_cnt   <= '0;
    end else begin
      if (accept) begin
        if (force_clr) begin
          lock     <= 1'b0;
          lock_cnt <= '0;
        end else begin
          if (op_in[win].attr.lock) begin
            lock       <= 1'b1;
            lock_owner <= win;
          end
          if (lock_hit) lock_cnt <= lock_cnt + 1'b1;
        end
      end else if ((rsp_done & ~op_q.attr.lock) | timeout) begin
        lock     <= 1'b0;
        lock_cnt <= '0;
      end
      if (idle_tick & ~timeout) idle_cnt <= idle_cnt + 1'b1;
      else                      idle_cnt <= '0;
    end
  end

  always_comb begin
    alu_src_a    = '0;
    alu_src_b    = '0;
    alu_control  = '0;
    alu_c_flag   = 1'b0;
    alu_is_arith = 1'b0;
    alu_is_adc   = 1'b0;
    alu_sh_carry = 1'b0;
    if (state == EXEC) begin
      alu_src_a    = op_q.a;
      alu_src_b    = op_q.b;
      alu_control  = op_q.ctrl;
      alu_c_flag   = op_q.attr.chain_c ? prev_c : op_q.attr.c_flag;
      alu_is_arith = op_q.attr.is_arith;
      alu_is_adc   = op_q.attr.is_adc;
      alu_sh_carry = ~op_q.attr.is_arith & op_q.attr.c_flag;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU standing in for the real one.
module tb_alu_arbiter;
  localparam logic [3:0] OP_AND = 4'h0, OP_SUB = 4'h2, OP_ADD = 4'h4, OP_ORR = 4'hC;
  // attr = {LOCK, CHAIN_C, C_FLAG, IS_ARITH, IS_ADC}
  localparam logic [4:0] AT_ARITH = 5'b00010, AT_LOCK = 5'b10010, AT_ADC_CH = 5'b01011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [63:0] req_src_a, req_src_b;
  logic [7:0]  req_ctrl;
  logic [9:0]  req_attr;
  logic [31:0] rsp_result, alu_src_a, alu_src_b, alu_result;
  logic [3:0]  rsp_flags, alu_control, alu_flags;
  logic        alu_c_flag, alu_is_arith, alu_is_adc, alu_sh_carry;

  int n_chk = 0, n_pass = 0;
  int gq[$], rid[$];
  logic [31:0] rres[$];
  logic [3:0]  rflg[$];

  always #5 clk = ~clk;

  alu_arbiter #(.LOCK_MAX(4), .LOCK_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src_a(req_src_a), .req_src_b(req_src_b), .req_ctrl(req_ctrl), .req_attr(req_attr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .alu_c_flag(alu_c_flag), .alu_is_arith(alu_is_arith), .alu_is_adc(alu_is_adc),
    .alu_sh_carry(alu_sh_carry), .alu_result(alu_result), .alu_flags(alu_flags)
  );

  // reference ALU: flags {N,Z,C,V}, ARM-style carry (SUB carry = no borrow)
  logic [32:0] m_s;
  logic        m_c, m_v;
  always_comb begin
    m_s = '0;
    m_c = 1'b0;
    m_v = 1'b0;
    case (alu_control)
      OP_ADD: begin
        m_s = {1'b0, alu_src_a} + {1'b0, alu_src_b} + {32'b0, alu_is_adc & alu_c_flag};
        m_c = m_s[32];
        m_v = (alu_src_a[31] == alu_src_b[31]) && (m_s[31] != alu_src_a[31]);
      end
      OP_SUB: begin
        m_s = {1'b0, alu_src_a} + {1'b0, ~alu_src_b} + 33'd1;
        m_c = m_s[32];
        m_v = (alu_src_a[31] != alu_src_b[31]) && (m_s[31] != alu_src_a[31]);
      end
      OP_AND: begin m_s = {1'b0, alu_src_a & alu_src_b}; m_c = alu_sh_carry; end
      OP_ORR: begin m_s = {1'b0, alu_src_a | alu_src_b}; m_c = alu_sh_carry; end
      default: m_s = '0;
    endcase
  end
  assign alu_result = m_s[31:0];
  assign alu_flags  = {m_s[31], m_s[31:0] == 32'd0, m_c, m_v};

  // log grants and consumed responses away from the active edge
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (req_valid[i] && req_ready[i]) gq.push_back(i);
      if (rsp_valid[i] && rsp_ready[i]) begin
        rid.push_back(i);
        rres.push_back(rsp_result);
        rflg.push_back(rsp_flags);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic set_req(input int i, input logic v, input logic [3:0] c,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] at);
    req_valid[i]          = v;
    req_src_a[32*i +: 32] = a;
    req_src_b[32*i +: 32] = b;
    req_ctrl[4*i +: 4]    = c;
    req_attr[5*i +: 5]    = at;
  endtask

  task automatic wait_acc(input int i, input string tag);
    logic ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_valid[i] && req_ready[i]) begin ok = 1'b1; break; end
    end
    chk({tag, "_acc"}, 64'(ok), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic drain(input int n, input string tag);
    for (int k = 0; k < 40; k++) begin
      if (rid.size() >= n) break;
      @(posedge clk); #1;
    end
    chk({tag, "_drain"}, 64'(rid.size() >= n), 64'd1);
  endtask

  task automatic clr_q();
    gq.delete(); rid.delete(); rres.delete(); rflg.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, c0, c1, bad;
    logic done;
    rst_n = 1'b0; req_valid = '0; rsp_ready = 2'b11;
    req_src_a = '0; req_src_b = '0; req_ctrl = '0; req_attr = '0;
    #12;
    chk("rst_rsp", 64'({req_ready, rsp_valid, rsp_flags, rsp_result}), 64'd0);
    chk("rst_alu_ab", {alu_src_a, alu_src_b}, 64'd0);
    chk("rst_alu_ctl", 64'({alu_control, alu_c_flag, alu_is_arith, alu_is_adc, alu_sh_carry}), 64'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: overflow add, two-cycle latency
    set_req(0, 1'b1, OP_ADD, 32'h7FFF_FFFF, 32'h1, AT_ARITH);
    wait_acc(0, "t1");
    set_req(0, 1'b0, OP_ADD, 32'h0, 32'h0, 5'b0);
    @(negedge clk);
    chk("t1_exec_valid", 64'(rsp_valid), 64'd0);
    chk("t1_exec_a", 64'(alu_src_a), 64'h7FFF_FFFF);
    chk("t1_exec_ctl", 64'({alu_control, alu_is_arith}), 64'({OP_ADD, 1'b1}));
    @(negedge clk);
    chk("t1_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("t1_result", 64'(rsp_result), 64'h8000_0000);
    chk("t1_flags", 64'(rsp_flags), 64'b1001);
    chk("t1_alu_idle", 64'(alu_src_a), 64'd0);
    @(posedge clk); #1;
    chk("t1_rsp_done", 64'(rsp_valid), 64'd0);

    // 2: both requesters continuously valid from reset
    do_reset();
    clr_q();
    set_req(0, 1'b1, OP_SUB, 32'd5, 32'd5, AT_ARITH);
    set_req(1, 1'b1, OP_ORR, 32'hF0, 32'h0F, 5'b00100);
    done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (gq.size() >= 4) begin done = 1'b1; break; end
    end
    chk("t2_grants_done", 64'(done), 64'd1);
    req_valid = '0;
    drain(4, "t2");
    for (int k = 0; k < 4 && k < gq.size() && k < rid.size(); k++) begin
      chk($sformatf("t2_grant%0d", k), 64'(gq[k]), 64'(k % 2));
      chk($sformatf("t2_res%0d", k), 64'(rres[k]), (k % 2 == 0) ? 64'd0 : 64'hFF);
      chk($sformatf("t2_flg%0d", k), 64'(rflg[k]), (k % 2 == 0) ? 64'b0110 : 64'b0010);
    end

    // 3: locked 64-bit add on req1, req0 waits behind the pair
    clr_q();
    set_req(1, 1'b1, OP_ADD, 32'hFFFF_FFFF, 32'h1, AT_LOCK);
    wait_acc(1, "t3a");
    set_req(1, 1'b1, OP_ADD, 32'hFFFF_FFFF, 32'h0, AT_ADC_CH);
    set_req(0, 1'b1, OP_AND, 32'h0F, 32'hFF, 5'b0);
    wait_acc(1, "t3b");
    chk("t3_chain_c", 64'(alu_c_flag), 64'd1);
    req_valid[1] = 1'b0;
    wait_acc(0, "t3c");
    req_valid[0] = 1'b0;
    drain(3, "t3");
    chk("t3_order", 64'(gq.size() == 3 && gq[0] == 1 && gq[1] == 1 && gq[2] == 0), 64'd1);
    if (rres.size() >= 3) begin
      chk("t3_lo", 64'({rres[0], rflg[0]}), 64'({32'h0, 4'b0110}));
      chk("t3_hi", 64'({rres[1], rflg[1]}), 64'({32'h0, 4'b0110}));
      chk("t3_r0", 64'({rres[2], rflg[2]}), 64'({32'h0F, 4'b0000}));
    end

    // 4: req1 keeps LOCK on 6 ops while req0 waits
    clr_q();
    set_req(1, 1'b1, OP_ADD, 32'd1, 32'd2, AT_LOCK);
    set_req(0, 1'b1, OP_AND, 32'hF0F0, 32'hFF00, 5'b0);
    done = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk); #1;
      c0 = 0; c1 = 0;
      foreach (gq[j]) if (gq[j] == 0) c0++; else c1++;
      if (c0 >= 1) req_valid[0] = 1'b0;
      if (c1 >= 6) begin req_valid[1] = 1'b0; done = 1'b1; break; end
    end
    chk("t4_done", 64'(done), 64'd1);
    chk("t4_ngrant", 64'(gq.size()), 64'd7);
    for (int k = 0; k < 7 && k < gq.size(); k++)
      chk($sformatf("t4_grant%0d", k), 64'(gq[k]), (k == 4) ? 64'd0 : 64'd1);

    // 5: lock still held by req1, owner goes idle, req0 waits for the timeout
    done = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid[1]) begin done = 1'b1; break; end
    end
    chk("t5_last_rsp", 64'(done), 64'd1);
    @(posedge clk); #1;
    set_req(0, 1'b1, OP_ADD, 32'h10, 32'h20, AT_ARITH);
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (req_ready[0]) begin n = k; break; end
    end
    chk("t5_release_cycle", 64'(n), 64'd9);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    drain(8, "t5");
    if (rres.size() >= 8) begin
      chk("t4_res0", 64'({rres[0], rflg[0]}), 64'({32'd3, 4'b0000}));
      chk("t4_res4", 64'({rres[4], rflg[4]}), 64'({32'hF000, 4'b0000}));
      chk("t5_res", 64'({rid[7], rres[7]}), 64'({32'd0, 32'h30}));
    end

    // 6: response back-pressure, then reset mid-EXEC
    rsp_ready = 2'b00;
    set_req(0, 1'b1, OP_ADD, 32'd2, 32'd3, AT_ARITH);
    wait_acc(0, "t6");
    req_valid[0] = 1'b0;
    set_req(1, 1'b1, OP_AND, 32'd1, 32'd1, 5'b0);
    @(negedge clk);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (!(rsp_valid == 2'b01 && rsp_result == 32'd5 && rsp_flags == 4'd0 && req_ready == 2'b00)) bad++;
    end
    chk("t6_hold", 64'(bad), 64'd0);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    rsp_ready = 2'b11;
    @(posedge clk); #1;
    chk("t6_release", 64'(rsp_valid), 64'd0);
    chk("t6_logged", 64'({rid[$], rres[$]}), 64'({32'd0, 32'd5}));

    set_req(0, 1'b1, OP_ADD, 32'd7, 32'd8, AT_ARITH);
    wait_acc(0, "t6r");
    req_valid[0] = 1'b0;
    chk("t6r_exec_a", 64'(alu_src_a), 64'd7);
    rst_n = 1'b0;
    #1;
    chk("t6r_rsp", 64'({req_ready, rsp_valid, rsp_flags, rsp_result}), 64'd0);
    chk("t6r_alu", {alu_src_a, alu_src_b}, 64'd0);
    chk("t6r_alu_ctl", 64'({alu_control, alu_c_flag, alu_is_arith, alu_is_adc, alu_sh_carry}), 64'd0);
    #1 rst_n = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (|rsp_valid) bad++;
    end
    chk("t6r_no_rsp", 64'(bad), 64'd0);
    chk("t6r_result", 64'(rsp_result), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
